a2d_spi_resp: RTL
=================

// Module: a2d_spi_resp
// PURPOSE
//  SPI responder (slave) for the A2D link: models the 8-channel 12-bit converter
//  read by the A2D master. Used in fullchip benches and on a second board.
//  Decodes the channel field of each 16-bit command frame.
//  Returns that channel's sample on the NEXT frame (pipelined, ADC128S-style).
// PARAMETERS
//  FRAME_BITS  16  SCLK rising edges per complete frame
//  DATA_W      12  sample width; MISO word = {(FRAME_BITS-DATA_W)'b0, sample}
//  CH_LSB      11  LSB of the 3-bit channel field in the received command
//  RESET_CH    0   channel addressed after reset
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       async active-low reset
//  SS_n       in   1       slave select from master (async; synchronised internally)
//  SCLK       in   1       SPI clock, mode 0 (async; synchronised internally)
//  MOSI       in   1       command data from master
//  MISO       out  1       sample data to master
//  ch_data    in   8*DATA_W  packed samples; ch N = ch_data[N*DATA_W +: DATA_W]
//  chnl       out  3       channel to be returned on the next frame
//  cmd_vld    out  1       1-clk pulse: complete frame accepted, chnl updated
//  frame_err  out  1       1-clk pulse: frame ended with bit count != FRAME_BITS
//  busy       out  1       high while a frame is in progress (state SHIFT)
// BEHAVIOUR
//  - Reset values: MISO=0, chnl=RESET_CH, cmd_vld=0, frame_err=0, busy=0.
//    Reset also clears both shift registers and the bit counter.
//  - SS_n, SCLK, MOSI: each double-flopped, then edge-detected on the synced value.
//    Input latency: 3 clk.
//  - Timing rule: SCLK high/low phases >= 4 clk; SS_n-fall to first SCLK rise >= 4 clk.
//  - FSM IDLE: busy=0. On synced SS_n fall -> SHIFT:
//    - tx_shft <= {pad, ch_data[chnl]}; sample frozen for the whole frame.
//    - rx_shft <= 0; bit_cnt <= 0.
//  - FSM SHIFT: busy=1.
//    - SCLK rise: rx_shft <= {rx_shft[FRAME_BITS-2:0], MOSI_sync}.
//      bit_cnt++, saturating at FRAME_BITS+1 so long frames count as errors.
//    - SCLK fall: tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0}.
//    - MISO = tx_shft[FRAME_BITS-1]; MSB is valid before the first rising edge.
//  - SS_n rise in SHIFT -> IDLE, next clk:
//    - If bit_cnt==FRAME_BITS: chnl <= rx_shft[CH_LSB+2:CH_LSB]; pulse cmd_vld.
//    - Otherwise: chnl unchanged; pulse frame_err.
//  - An SCLK edge in the same clk as the synced SS_n rise is ignored.
//  - SCLK edges while in IDLE are ignored (no shift, no count).
//  - ch_data changes mid-frame do not affect the word being shifted out.
//  - Reset mid-frame: return to IDLE immediately; no pulses; chnl=RESET_CH.
//  - Back-to-back frames: SS_n high >= 4 clk; the new chnl applies to the next frame.
// CONFIGURATION
//  A2D_RESP_HIZ_EN defined:
//    MISO = 1'bz whenever the FSM is in IDLE; shared-bus operation.
//  A2D_RESP_HIZ_EN undefined:
//    MISO driven 0 in IDLE; driven tx_shft MSB in SHIFT.
// TESTING
//  1 Reset, ch_data[0]=12'hA5C, frame with cmd ch=4 (MOSI 16'h2000):
//    - MISO word = 16'h0A5C.
//    - cmd_vld pulses once; chnl=4.
//  2 ch_data[4]=12'h3C1, ch_data[5]=12'hFFF; frame cmd ch=5 (16'h2800), then frame cmd ch=0:
//    - MISO words are 16'h03C1 then 16'h0FFF.
//    - chnl=0 after the second frame.
//  3 Short frame (10 SCLK rises, cmd ch=7):
//    - frame_err pulses; cmd_vld=0; chnl unchanged.
//    - Next frame returns the old channel's data.
//  4 ch_data[chnl] changed 12'h111->12'h222 mid-frame:
//    - Current word = 16'h0111; next frame = 16'h0222.
//  5 rst_n asserted after 7 SCLK rises:
//    - busy=0, MISO=0 (z with HIZ), chnl=RESET_CH; no pulses.
//    - Following full frame returns ch_data[0].
//  6 SCLK toggled with SS_n high:
//    - No state change.
//    - With A2D_RESP_HIZ_EN, MISO stays z.

Source files
------------

// File: rtl/a2d_spi_resp.sv
`default_nettype none
// ============================================================================
// a2d_spi_resp : SPI mode-0 responder modelling an 8-channel 12-bit A2D with
//                pipelined channel selection. Optional: A2D_RESP_HIZ_EN.
// Revision     : 1.0
// ============================================================================
module a2d_spi_resp #(
  parameter int FRAME_BITS = 16,
  parameter int DATA_W     = 12,
  parameter int CH_LSB     = 11,
  parameter int RESET_CH   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                SCLK,
  input  logic                MOSI,
  output logic                MISO,
  input  logic [8*DATA_W-1:0] ch_data,
  output logic [2:0]          chnl,
  output logic                cmd_vld,
  output logic                frame_err,
  output logic                busy
);

  localparam int             CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam int             PAD_W    = FRAME_BITS - DATA_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              chnl_q, chnl_d;
  logic                    cmd_vld_q, cmd_vld_d;
  logic                    frame_err_q, frame_err_d;

  logic ss_meta_q, ss_sync_q, ss_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic [DATA_W-1:0] ch_w [8];
  logic [DATA_W-1:0] sample_w;
  logic              ss_fall_w, ss_rise_w, sclk_rise_w, sclk_fall_w;

  // Sync flops reset low so a slave select still asserted after reset is not
  // mistaken for a new frame start; a resulting rise in IDLE is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_meta_q   <= 1'b0;
      ss_sync_q   <= 1'b0;
      ss_prev_q   <= 1'b0;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      ss_meta_q   <= SS_n;
      ss_sync_q   <= ss_meta_q;
      ss_prev_q   <= ss_sync_q;
      sclk_meta_q <= SCLK;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= MOSI;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign ss_fall_w   =  ss_prev_q   & ~ss_sync_q;
  assign ss_rise_w   = ~ss_prev_q   &  ss_sync_q;
  assign sclk_rise_w = ~sclk_prev_q &  sclk_sync_q;
  assign sclk_fall_w =  sclk_prev_q & ~sclk_sync_q;

  for (genvar g = 0; g < 8; g++) begin : g_ch
    assign ch_w[g] = ch_data[g*DATA_W +: DATA_W];
  end

  assign sample_w = ch_w[chnl_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      chnl_q      <= 3'(RESET_CH);
      cmd_vld_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      chnl_q      <= chnl_d;
      cmd_vld_q   <= cmd_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    chnl_d      = chnl_q;
    cmd_vld_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall_w) begin
          state_d = SHIFT;
          tx_d    = {{PAD_W{1'b0}}, sample_w};
          rx_d    = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // Frame end takes priority over any SCLK edge seen in the same clock.
        if (ss_rise_w) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) begin
            chnl_d    = rx_q[CH_LSB+2:CH_LSB];
            cmd_vld_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (sclk_rise_w) begin
            rx_d = {rx_q[FRAME_BITS-2:0], mosi_sync_q};
            if (cnt_q != CNT_SAT) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (sclk_fall_w) begin
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign chnl      = chnl_q;
  assign cmd_vld   = cmd_vld_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == SHIFT);

`ifdef A2D_RESP_HIZ_EN
  assign MISO = (state_q == SHIFT) ? tx_q[FRAME_BITS-1] : 1'bz;
`else
  assign MISO = (state_q == SHIFT) & tx_q[FRAME_BITS-1];
`endif

endmodule
`default_nettype wire
